// File: rtl/mbist_pkg.sv
// Shared definitions for the MBIST fault-injection campaign: fault-kind codes,
// campaign FSM states and the saturating counter helper.
package mbist_pkg;

  localparam logic [2:0] FK_NONE = 3'd0;
  localparam logic [2:0] FK_SA0  = 3'd1;
  localparam logic [2:0] FK_SA1  = 3'd2;
  localparam logic [2:0] FK_INV  = 3'd3;
  localparam logic [2:0] FK_TR   = 3'd4;
  localparam logic [2:0] FK_WB   = 3'd5;
  localparam logic [2:0] FK_TFR  = 3'd6;
  localparam logic [2:0] FK_CPL  = 3'd7;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SEEK,
    ST_APPLY,
    ST_RELEASE,
    ST_LAUNCH,
    ST_WAIT,
    ST_RECORD,
    ST_ADVANCE,
    ST_DONE
  } campaign_state_e;

  // Increment that sticks at the all-ones value of a width-bit counter (width <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
    logic [31:0] limit;
    limit = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (value >= limit) ? limit : value + 32'd1;
  endfunction

endpackage

// File: rtl/mbist_watchdog.sv
// Clearable per-test watchdog; expired is high while enabled at count TIMEOUT_CYCLES-1.
module mbist_watchdog
  import mbist_pkg::*;
#(
  parameter int unsigned TO_WIDTH       = 24,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TO_WIDTH-1:0] TERMINAL = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [TO_WIDTH-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (enable && count != TERMINAL)
      count <= count + TO_WIDTH'(1);
  end

  assign expired = enable && (count == TERMINAL);

endmodule

// File: rtl/mbist_fault_campaign.sv
// MBIST fault-injection campaign sequencer: sweeps enabled fault kinds over an
// address window. Optional MBIST_CAMPAIGN_STOP_ON_MISS_EN stops at the first escape.
module mbist_fault_campaign
  import mbist_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned KIND_WIDTH     = 3,
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned TO_WIDTH       = 24,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TARGET_XOR     = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       campaign_start,
  input  logic [2**KIND_WIDTH-1:0]   kind_mask,
  input  logic [ADDR_WIDTH-1:0]      addr_lo,
  input  logic [ADDR_WIDTH-1:0]      addr_hi,
  output logic                       inj_fault_enable,
  output logic [ADDR_WIDTH-1:0]      inj_fault_addr,
  output logic [KIND_WIDTH-1:0]      inj_fault_type,
  output logic [ADDR_WIDTH-1:0]      inj_fault_target,
  output logic                       bist_rst_n,
  output logic                       bist_start,
  input  logic                       bist_test_done,
  input  logic                       bist_fail_flag,
  input  logic [ADDR_WIDTH-1:0]      bist_fail_addr,
  output logic                       busy,
  output logic                       done,
  output logic [CNT_WIDTH-1:0]       total_tests,
  output logic [CNT_WIDTH-1:0]       detected,
  output logic [CNT_WIDTH-1:0]       timeouts,
  output logic                       res_valid,
  output logic [KIND_WIDTH-1:0]      res_kind,
  output logic [ADDR_WIDTH-1:0]      res_addr,
  output logic                       res_detected,
  output logic                       res_timeout,
  output logic [ADDR_WIDTH-1:0]      res_fail_addr
);

  localparam int unsigned            NUM_KINDS   = 2**KIND_WIDTH;
  localparam logic [KIND_WIDTH-1:0]  MAX_KIND    = '1;
  localparam int unsigned            SW          = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0]          SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  campaign_state_e         state, state_next;
  logic [KIND_WIDTH-1:0]   cur_kind, seek_kind;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic [SW-1:0]           settle_cnt;
  logic                    seek_found, settle_last, wd_expired;

  mbist_watchdog #(
    .TO_WIDTH       (TO_WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state == ST_LAUNCH),
    .enable  (state == ST_WAIT),
    .expired (wd_expired)
  );

  // Lowest enabled kind at or above cur_kind, so masked-off kinds cost no cycles.
  always_comb begin
    seek_found = 1'b0;
    seek_kind  = cur_kind;
    for (int unsigned k = 1; k < NUM_KINDS; k++) begin
      if (!seek_found && kind_mask[KIND_WIDTH'(k)] && k >= 32'(cur_kind)) begin
        seek_found = 1'b1;
        seek_kind  = KIND_WIDTH'(k);
      end
    end
  end

  assign settle_last = (settle_cnt == SETTLE_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE, ST_DONE: if (campaign_start) state_next = ST_SEEK;
      ST_SEEK:          state_next = (!seek_found || addr_lo > addr_hi) ? ST_DONE : ST_APPLY;
      ST_APPLY:         if (settle_last) state_next = ST_RELEASE;
      ST_RELEASE:       if (settle_last) state_next = ST_LAUNCH;
      ST_LAUNCH:        state_next = ST_WAIT;
      ST_WAIT:          if (bist_test_done || wd_expired) state_next = ST_RECORD;
`ifdef MBIST_CAMPAIGN_STOP_ON_MISS_EN
      ST_RECORD:        state_next = res_detected ? ST_ADVANCE : ST_DONE;
`else
      ST_RECORD:        state_next = ST_ADVANCE;
`endif
      ST_ADVANCE:       state_next = (cur_addr == addr_hi && cur_kind == MAX_KIND) ? ST_DONE : ST_SEEK;
      default:          state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_kind         <= '0;
      cur_addr         <= '0;
      settle_cnt       <= '0;
      inj_fault_enable <= 1'b0;
      inj_fault_addr   <= '0;
      inj_fault_type   <= KIND_WIDTH'(FK_NONE);
      inj_fault_target <= '0;
      total_tests      <= '0;
      detected         <= '0;
      timeouts         <= '0;
      res_kind         <= '0;
      res_addr         <= '0;
      res_detected     <= 1'b0;
      res_timeout      <= 1'b0;
      res_fail_addr    <= '0;
    end else begin
      if (state != state_next)
        settle_cnt <= '0;
      else if (state == ST_APPLY || state == ST_RELEASE)
        settle_cnt <= settle_cnt + SW'(1);

      unique case (state)
        ST_IDLE, ST_DONE: if (campaign_start) begin
          total_tests <= '0;
          detected    <= '0;
          timeouts    <= '0;
          cur_kind    <= KIND_WIDTH'(FK_SA0);
          cur_addr    <= addr_lo;
        end
        ST_SEEK: if (state_next == ST_APPLY) begin
          cur_kind         <= seek_kind;
          inj_fault_enable <= 1'b1;
          inj_fault_type   <= seek_kind;
          inj_fault_addr   <= cur_addr;
          inj_fault_target <= cur_addr ^ ADDR_WIDTH'(TARGET_XOR);
        end
        // test_done takes priority over a coincident watchdog expiry
        ST_WAIT: if (bist_test_done) begin
          res_kind      <= cur_kind;
          res_addr      <= cur_addr;
          res_detected  <= bist_fail_flag;
          res_timeout   <= 1'b0;
          res_fail_addr <= bist_fail_addr;
        end else if (wd_expired) begin
          res_kind      <= cur_kind;
          res_addr      <= cur_addr;
          res_detected  <= 1'b0;
          res_timeout   <= 1'b1;
          res_fail_addr <= '0;
        end
        ST_RECORD: begin
          total_tests <= CNT_WIDTH'(sat_inc(32'(total_tests), CNT_WIDTH));
          if (res_detected) detected <= CNT_WIDTH'(sat_inc(32'(detected), CNT_WIDTH));
          if (res_timeout)  timeouts <= CNT_WIDTH'(sat_inc(32'(timeouts), CNT_WIDTH));
        end
        ST_ADVANCE: if (cur_addr == addr_hi) begin
          cur_addr <= addr_lo;
          if (cur_kind != MAX_KIND) cur_kind <= cur_kind + KIND_WIDTH'(1);
        end else begin
          cur_addr <= cur_addr + ADDR_WIDTH'(1);
        end
        default: ;
      endcase

      if (state != ST_DONE && state_next == ST_DONE)
        inj_fault_enable <= 1'b0;
    end
  end

  assign busy       = (state != ST_IDLE) && (state != ST_DONE);
  assign done       = (state == ST_DONE);
  assign res_valid  = (state == ST_RECORD);
  assign bist_start = (state == ST_LAUNCH);
  assign bist_rst_n = reset_n & (state != ST_APPLY);

endmodule

// File: tb/tb_mbist_fault_campaign.sv
// Bench for mbist_fault_campaign: behavioural controller stub plus a list-based
// model of the sweep order and per-test outcomes.
module tb_mbist_fault_campaign;

  localparam int unsigned AW = 8;
  localparam int unsigned KW = 3;
  localparam int unsigned CW = 16;
  localparam int unsigned TO = 100;
  localparam int unsigned ST = 4;

  typedef struct { int kind; int addr; } test_t;
  typedef struct { bit det; bit to; int fa; bit chk_fa; } outcome_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              campaign_start = 1'b0;
  logic [7:0]        kind_mask = '0;
  logic [AW-1:0]     addr_lo = '0, addr_hi = '0;
  logic              bist_test_done = 1'b0, bist_fail_flag = 1'b0;
  logic [AW-1:0]     bist_fail_addr = '0;
  logic              inj_fault_enable, bist_rst_n, bist_start, busy, done;
  logic [AW-1:0]     inj_fault_addr, inj_fault_target, res_addr, res_fail_addr;
  logic [KW-1:0]     inj_fault_type, res_kind;
  logic [CW-1:0]     total_tests, detected, timeouts;
  logic              res_valid, res_detected, res_timeout;

  int checks = 0, errors = 0;
  test_t    exp_q[$];
  outcome_t out_q[$];
  int stub_mode = 0, stub_miss = -1, stub_idx = 0, strobes = 0;
  int exp_n, exp_det, exp_to, exp_last_addr;

  mbist_fault_campaign #(
    .ADDR_WIDTH(AW), .KIND_WIDTH(KW), .CNT_WIDTH(CW), .TO_WIDTH(24),
    .TIMEOUT_CYCLES(TO), .SETTLE_CYCLES(ST), .TARGET_XOR(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .campaign_start(campaign_start),
    .kind_mask(kind_mask), .addr_lo(addr_lo), .addr_hi(addr_hi),
    .inj_fault_enable(inj_fault_enable), .inj_fault_addr(inj_fault_addr),
    .inj_fault_type(inj_fault_type), .inj_fault_target(inj_fault_target),
    .bist_rst_n(bist_rst_n), .bist_start(bist_start),
    .bist_test_done(bist_test_done), .bist_fail_flag(bist_fail_flag),
    .bist_fail_addr(bist_fail_addr), .busy(busy), .done(done),
    .total_tests(total_tests), .detected(detected), .timeouts(timeouts),
    .res_valid(res_valid), .res_kind(res_kind), .res_addr(res_addr),
    .res_detected(res_detected), .res_timeout(res_timeout),
    .res_fail_addr(res_fail_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Controller stub: mode 0 = done after random latency (miss at stub_miss),
  // mode 1 = never done, mode 2 = done exactly in the watchdog terminal cycle.
  initial begin : stub
    outcome_t o;
    int lat, idx;
    forever begin
      @(negedge clk);
      if (reset_n && bist_start) begin
        idx = stub_idx;
        stub_idx++;
        if (stub_mode == 1) begin
          o = '{det: 1'b0, to: 1'b1, fa: 0, chk_fa: 1'b0};
          out_q.push_back(o);
        end else begin
          lat = (stub_mode == 2) ? int'(TO) : int'($urandom_range(1, 20));
          o = '{det: !(stub_mode == 0 && idx == stub_miss), to: 1'b0,
                fa: int'($urandom_range(0, 255)), chk_fa: 1'b1};
          out_q.push_back(o);
          @(negedge clk);
          repeat (lat - 1) @(negedge clk);
          bist_test_done = 1'b1;
          bist_fail_flag = o.det;
          bist_fail_addr = AW'(o.fa);
          @(negedge clk);
          bist_test_done = 1'b0;
          bist_fail_flag = 1'b0;
        end
      end
    end
  end

  // Per-test protocol monitor and result scoreboard.
  initial begin : monitor
    int rst_run, start_run;
    test_t t;
    outcome_t o;
    rst_run = 0;
    start_run = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        rst_run = 0;
        start_run = 0;
      end else begin
        if (!bist_rst_n) rst_run++;
        else if (rst_run > 0) begin
          chk("bist_rst_low_cycles", rst_run, ST);
          rst_run = 0;
        end
        if (bist_start) begin
          start_run++;
          checks++;
          assert (exp_q.size() > 0) else begin
            errors++;
            $error("FAIL unexpected_launch: observed launch, required none");
          end
          if (exp_q.size() > 0) begin
            t = exp_q[0];
            chk("inj_enable", inj_fault_enable, 1);
            chk("inj_type", inj_fault_type, t.kind);
            chk("inj_addr", inj_fault_addr, t.addr);
            chk("inj_target", inj_fault_target, t.addr ^ 1);
          end
        end else if (start_run > 0) begin
          chk("bist_start_width", start_run, 1);
          start_run = 0;
        end
        if (res_valid) begin
          strobes++;
          checks++;
          assert (exp_q.size() > 0 && out_q.size() > 0) else begin
            errors++;
            $error("FAIL unexpected_result: observed strobe, required none");
          end
          if (exp_q.size() > 0 && out_q.size() > 0) begin
            t = exp_q.pop_front();
            o = out_q.pop_front();
            chk("res_kind", res_kind, t.kind);
            chk("res_addr", res_addr, t.addr);
            chk("res_detected", res_detected, o.det);
            chk("res_timeout", res_timeout, o.to);
            if (o.chk_fa) chk("res_fail_addr", res_fail_addr, o.fa);
          end
        end
      end
    end
  end

  task automatic start_campaign(input logic [7:0] mask, input int lo, input int hi,
                                input int mode, input int miss);
    exp_q.delete();
    out_q.delete();
    stub_mode = mode;
    stub_miss = miss;
    stub_idx  = 0;
    strobes   = 0;
    for (int k = 1; k < 8; k++)
      if (mask[k])
        for (int a = lo; a <= hi; a++) exp_q.push_back('{kind: k, addr: a});
    exp_n = exp_q.size();
    exp_det = (mode == 1) ? 0 : exp_n;
    exp_to  = (mode == 1) ? exp_n : 0;
    if (mode == 0 && miss >= 0 && miss < exp_n) begin
`ifdef MBIST_CAMPAIGN_STOP_ON_MISS_EN
      exp_n = miss + 1;
      while (exp_q.size() > exp_n) void'(exp_q.pop_back());
`endif
      exp_det = exp_n - 1;
    end
    exp_last_addr = (exp_n > 0) ? exp_q[exp_n-1].addr : 0;
    kind_mask = mask;
    addr_lo = AW'(lo);
    addr_hi = AW'(hi);
    @(negedge clk);
    campaign_start = 1'b1;
    @(negedge clk);
    campaign_start = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    campaign_start = 1'b1;
    @(negedge clk);
    campaign_start = 1'b0;
  endtask

  task automatic finish_campaign();
    int budget;
    budget = exp_n * (int'(TO) + 40) + 50;
    for (int i = 0; i < budget && done !== 1'b1; i++) @(negedge clk);
    chk("campaign_done", done, 1);
    chk("busy_after", busy, 0);
    chk("inj_enable_after", inj_fault_enable, 0);
    chk("total_tests", total_tests, exp_n);
    chk("detected", detected, exp_det);
    chk("timeouts", timeouts, exp_to);
    chk("strobes", strobes, exp_n);
    chk("pending_tests", exp_q.size(), 0);
    if (exp_n > 0) chk("res_addr_final", res_addr, exp_last_addr);
  endtask

  initial begin : main
    logic [7:0] m;
    int lo, hi, miss;

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_inj_enable", inj_fault_enable, 0);
    chk("rst_bist_start", bist_start, 0);
    chk("rst_total", total_tests, 0);
    chk("rst_res_valid", res_valid, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_bist_rst_n", bist_rst_n, 1);

    // Full SA0 sweep over the whole address space.
    start_campaign(8'h02, 0, 255, 0, -1);
    chk("busy_running", busy, 1);
    finish_campaign();

    // Two kinds over a small window, with a start pulse while busy.
    start_campaign(8'h0A, 10, 12, 0, -1);
    repeat (40) @(negedge clk);
    pulse_start();
    finish_campaign();

    // Nothing enabled beyond FK_NONE, and an inverted window.
    start_campaign(8'h01, 0, 255, 0, -1);
    repeat (2) @(negedge clk);
    chk("empty_mask_done", done, 1);
    chk("empty_mask_total", total_tests, 0);
    chk("empty_mask_strobes", strobes, 0);
    start_campaign(8'hFE, 5, 4, 0, -1);
    repeat (2) @(negedge clk);
    chk("inverted_done", done, 1);
    chk("inverted_total", total_tests, 0);

    // Top address with the highest kind: one test, no wrap.
    start_campaign(8'h80, 255, 255, 0, -1);
    finish_campaign();

    // Watchdog timeouts, then test_done coinciding with the terminal cycle.
    start_campaign(8'h10, 20, 22, 1, -1);
    finish_campaign();
    start_campaign(8'h40, 100, 101, 2, -1);
    finish_campaign();

    // Escape at the third test.
    start_campaign(8'h08, 0, 5, 0, 2);
    finish_campaign();
`ifdef MBIST_CAMPAIGN_STOP_ON_MISS_EN
    chk("stop_res_detected", res_detected, 0);
`endif

    // Randomized campaigns.
    for (int r = 0; r < 4; r++) begin
      m    = 8'($urandom_range(0, 255));
      lo   = int'($urandom_range(0, 250));
      hi   = lo + int'($urandom_range(0, 4));
      miss = int'($urandom_range(0, 6)) - 1;
      start_campaign(m, lo, hi, 0, miss);
      finish_campaign();
    end

    // Reset pulled mid-WAIT during the second test.
    start_campaign(8'h04, 0, 3, 1, -1);
    for (int i = 0; i < 400 && strobes < 1; i++) @(negedge clk);
    chk("pre_reset_strobes", strobes, 1);
    for (int i = 0; i < 40 && bist_start !== 1'b1; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_inj_enable", inj_fault_enable, 0);
    chk("mid_rst_inj_addr", inj_fault_addr, 0);
    chk("mid_rst_total", total_tests, 0);
    chk("mid_rst_timeouts", timeouts, 0);
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_res_kind", res_kind, 0);
    chk("mid_rst_bist_start", bist_start, 0);
    exp_q.delete();
    out_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_bist_rst_n", bist_rst_n, 1);
    chk("post_rst_idle", busy, 0);

    start_campaign(8'h22, 30, 33, 0, -1);
    finish_campaign();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
